spi_reg_writer: RTL

//   SPI controller (initiator) that issues register-write frames to the SPI peripheral that owns
//   en_reg_out_*, en_reg_pwm_* and pwm_duty_cycle.

---
 rtl/spi_reg_writer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/spi_reg_writer.sv
// SPI mode-0 initiator that sends one 16-bit {rw, addr[6:0], data[7:0]} frame per accepted start.
// Optional readback (macro SPI_READBACK_EN) adds the cipo input and the rdata output.
module spi_reg_writer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       wr,
  input  logic [6:0] addr,
  input  logic [7:0] data,
`ifdef SPI_READBACK_EN
  input  logic       cipo,
  output logic [7:0] rdata,
`endif
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       ncs,
  output logic       copi
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] div, div_nx;
  logic [3:0]    bit_cnt, bit_cnt_nx;
  logic          phase, phase_nx;
  logic [15:0]   shreg, shreg_nx;
  logic          sclk_nx, ncs_nx, busy_nx, done_nx;
  logic          tick;

`ifdef SPI_READBACK_EN
  logic [7:0] rx_shreg, rx_shreg_nx, rdata_nx;
`endif

  // The frame MSB always sits in shreg[15]; gating with ncs keeps copi low between frames.
  assign copi = shreg[15] & ~ncs;
  assign tick = (state != IDLE) && (div == DIV_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div     <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
      shreg   <= '0;
      sclk    <= 1'b0;
      ncs     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      div     <= div_nx;
      bit_cnt <= bit_cnt_nx;
      phase   <= phase_nx;
      shreg   <= shreg_nx;
      sclk    <= sclk_nx;
      ncs     <= ncs_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    div_nx     = '0;
    bit_cnt_nx = bit_cnt;
    phase_nx   = phase;
    shreg_nx   = shreg;
    sclk_nx    = sclk;
    ncs_nx     = ncs;
    busy_nx    = busy;
    done_nx    = 1'b0;

    if (state != IDLE) begin
      div_nx = tick ? '0 : div + 1'b1;
    end

    case (state)
      IDLE: begin
        if (start) begin
          shreg_nx   = {wr, addr, data};
          state_nx   = SETUP;
          busy_nx    = 1'b1;
          ncs_nx     = 1'b0;
          bit_cnt_nx = '0;
          phase_nx   = 1'b0;
        end
      end
      SETUP: begin
        if (tick) state_nx = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          sclk_nx  = ~sclk;
          phase_nx = ~phase;
          // phase=1 means this tick is a falling edge: advance to the next bit or finish.
          if (phase) begin
            if (bit_cnt == 4'd15) begin
              state_nx = HOLD;
            end else begin
              shreg_nx   = {shreg[14:0], 1'b0};
              bit_cnt_nx = bit_cnt + 4'd1;
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_nx = GAP;
          ncs_nx   = 1'b1;
        end
      end
      GAP: begin
        if (tick) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef SPI_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shreg <= '0;
      rdata    <= '0;
    end else begin
      rx_shreg <= rx_shreg_nx;
      rdata    <= rdata_nx;
    end
  end

  // Rising ticks with bit_cnt 8..15 carry frame bits 7..0.
  always_comb begin
    rx_shreg_nx = rx_shreg;
    rdata_nx    = rdata;
    if (state == SHIFT && tick && !phase && bit_cnt[3]) begin
      rx_shreg_nx = {rx_shreg[6:0], cipo};
    end
    if (state == GAP && tick) begin
      rdata_nx = rx_shreg;
    end
  end
`endif

endmodule
